// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the dynamic branch predictor: branch type
// codes, 2-bit counter states and BTB field width helpers.
package branch_predictor_pkg;

    typedef enum logic [2:0] {
        NOBRANCH = 3'd0,
        BEQ      = 3'd1,
        BNE      = 3'd2,
        BLT      = 3'd3,
        BLTU     = 3'd4,
        BGE      = 3'd5,
        BGEU     = 3'd6
    } br_type_e;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Word-aligned PCs: bits [1:0] never take part in indexing or tagging.
    function automatic int bp_tag_w(input int index_w);
        return 32 - index_w - 2;
    endfunction

    function automatic int bp_entries(input int index_w);
        return 1 << index_w;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Predictor bundle: IF-side lookup and EX-side resolve/redirect signals.
// master = pipeline side, slave = predictor.
interface branch_predictor_if;
    import branch_predictor_pkg::*;

    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic [31:0] PCE;
    br_type_e    BranchTypeE;
    logic        BranchE;
    logic [31:0] BrTargetE;
    logic        PredTakenE;
    logic [31:0] PredTargetE;
    logic        StallE;
    logic        FlushE;
    logic        MispredictE;
    logic [31:0] RecoverPCE;

    modport master (
        output PCF, PCE, BranchTypeE, BranchE, BrTargetE, PredTakenE,
               PredTargetE, StallE, FlushE,
        input  PredTakenF, PredTargetF, MispredictE, RecoverPCE
    );

    modport slave (
        input  PCF, PCE, BranchTypeE, BranchE, BrTargetE, PredTakenE,
               PredTargetE, StallE, FlushE,
        output PredTakenF, PredTargetF, MispredictE, RecoverPCE
    );

endinterface

// File: rtl/branch_predictor_sat_counter.sv
// bp_sat_counter: next state of a 2-bit saturating taken/not-taken counter.
module bp_sat_counter
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cnt_i,
    input  logic       taken_i,
    output logic [1:0] cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (taken_i && cnt_i != ST)
            cnt_o = cnt_i + 2'd1;
        else if (!taken_i && cnt_i != SNT)
            cnt_o = cnt_i - 2'd1;
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency IF lookup, EX update and
// misprediction redirect. Define BP_STATS_EN to add branch/mispredict counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int         INDEX_W  = 6,
    parameter logic [1:0] CNT_INIT = WNT,
    parameter int         CNT_W    = 2
) (
    input  logic clk,
    input  logic rst,
    branch_predictor_if.slave bp
`ifdef BP_STATS_EN
    ,
    output logic [31:0] BrCountO,
    output logic [31:0] MissCountO
`endif
);

    localparam int TAG_W   = bp_tag_w(INDEX_W);
    localparam int ENTRIES = bp_entries(INDEX_W);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];
    logic [CNT_W-1:0]   cnt_q [ENTRIES];

    logic [INDEX_W-1:0] idx_f, idx_e;
    logic [TAG_W-1:0]   tag_f, tag_e;
    logic               hit_f, hit_e, upd_e;
    logic [CNT_W-1:0]   cnt_sat, cnt_d;

    assign idx_f = bp.PCF[INDEX_W+1:2];
    assign tag_f = bp.PCF[31:INDEX_W+2];
    assign idx_e = bp.PCE[INDEX_W+1:2];
    assign tag_e = bp.PCE[31:INDEX_W+2];

    // Lookup reads the registered table, so a same-index write lands next cycle.
    assign hit_f          = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign bp.PredTakenF  = hit_f && cnt_q[idx_f][CNT_W-1];
    assign bp.PredTargetF = bp.PredTakenF ? tgt_q[idx_f] : '0;

    assign upd_e = (bp.BranchTypeE != NOBRANCH) && !bp.StallE && !bp.FlushE;
    assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

    bp_sat_counter u_sat (
        .cnt_i   (cnt_q[idx_e]),
        .taken_i (bp.BranchE),
        .cnt_o   (cnt_sat)
    );

    assign cnt_d = hit_e ? cnt_sat : (bp.BranchE ? WT : CNT_INIT);

    assign bp.MispredictE = upd_e &&
        ((bp.BranchE != bp.PredTakenE) ||
         (bp.BranchE && bp.PredTakenE && (bp.PredTargetE != bp.BrTargetE)));
    assign bp.RecoverPCE = !bp.MispredictE ? '0 :
                           (bp.BranchE ? bp.BrTargetE : bp.PCE + 32'd4);

    always_ff @(posedge clk) begin
        if (rst)
            valid_q <= '0;
        else if (upd_e)
            valid_q[idx_e] <= 1'b1;
    end

    // Payload needs no reset: valid_q masks it until the first allocation.
    always_ff @(posedge clk) begin
        if (!rst && upd_e) begin
            tag_q[idx_e] <= tag_e;
            cnt_q[idx_e] <= cnt_d;
            if (!hit_e || bp.BranchE)
                tgt_q[idx_e] <= bp.BrTargetE;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] br_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (upd_e)
                br_cnt_q <= br_cnt_q + 32'd1;
            if (bp.MispredictE)
                miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign BrCountO   = br_cnt_q;
    assign MissCountO = miss_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized bench for branch_predictor against an array-based BTB model;
// stats outputs are checked when BP_STATS_EN is defined.
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    localparam int IW = 6;
    localparam int N  = 1 << IW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_predictor_if bpi();

`ifdef BP_STATS_EN
    logic [31:0] br_cnt, miss_cnt;
`endif

    branch_predictor #(.INDEX_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bpi)
`ifdef BP_STATS_EN
        ,
        .BrCountO   (br_cnt),
        .MissCountO (miss_cnt)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference BTB: plain arrays, counter as an integer clamped to 0..3.
    bit          m_v   [N];
    int unsigned m_tag [N];
    logic [31:0] m_tgt [N];
    int          m_cnt [N];
    int unsigned m_br, m_miss;

    task automatic chk(input string tg, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tg, got, exp);
        end
    endtask

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic int unsigned m_tg(input logic [31:0] pc);
        return pc >> (IW + 2);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_v[m_idx(pc)] && m_tag[m_idx(pc)] == m_tg(pc);
    endfunction

    function automatic bit m_taken(input logic [31:0] pc);
        return m_hit(pc) && m_cnt[m_idx(pc)] >= 2;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) m_v[i] = 1'b0;
        m_br = 0;
        m_miss = 0;
    endtask

    task automatic drive(input logic [31:0] pcf, input br_type_e ty, input logic [31:0] pce,
                         input logic br, input logic [31:0] tgt, input logic pte,
                         input logic [31:0] ptg, input logic stall, input logic flush);
        bpi.PCF = pcf;         bpi.BranchTypeE = ty;  bpi.PCE = pce;
        bpi.BranchE = br;      bpi.BrTargetE = tgt;   bpi.PredTakenE = pte;
        bpi.PredTargetE = ptg; bpi.StallE = stall;    bpi.FlushE = flush;
    endtask

    // Check this cycle's outputs against the model, then clock both.
    task automatic step();
        bit upd, mis;
        logic [31:0] rec, e_tgt;
        int i;
        @(negedge clk);
        upd = bpi.BranchTypeE != NOBRANCH && !bpi.StallE && !bpi.FlushE;
        mis = upd && (bpi.BranchE != bpi.PredTakenE ||
                      (bpi.BranchE && bpi.PredTakenE && bpi.PredTargetE != bpi.BrTargetE));
        rec = !mis ? 32'h0 : (bpi.BranchE ? bpi.BrTargetE : bpi.PCE + 32'd4);
        e_tgt = m_taken(bpi.PCF) ? m_tgt[m_idx(bpi.PCF)] : 32'h0;
        chk("pred_taken", {31'h0, bpi.PredTakenF}, {31'h0, m_taken(bpi.PCF)});
        chk("pred_target", bpi.PredTargetF, e_tgt);
        chk("mispredict", {31'h0, bpi.MispredictE}, {31'h0, mis});
        chk("recover_pc", bpi.RecoverPCE, rec);
`ifdef BP_STATS_EN
        chk("br_count", br_cnt, m_br);
        chk("miss_count", miss_cnt, m_miss);
`endif
        @(posedge clk);
        if (rst) begin
            m_reset();
        end else begin
            if (upd) begin
                i = m_idx(bpi.PCE);
                if (m_hit(bpi.PCE)) begin
                    m_cnt[i] = bpi.BranchE ? (m_cnt[i] == 3 ? 3 : m_cnt[i] + 1)
                                           : (m_cnt[i] == 0 ? 0 : m_cnt[i] - 1);
                    if (bpi.BranchE) m_tgt[i] = bpi.BrTargetE;
                end else begin
                    m_v[i] = 1'b1;
                    m_tag[i] = m_tg(bpi.PCE);
                    m_tgt[i] = bpi.BrTargetE;
                    m_cnt[i] = bpi.BranchE ? 2 : 1;
                end
                m_br++;
            end
            if (mis) m_miss++;
        end
        #1;
    endtask

    function automatic logic [31:0] rpc();
        if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
        return (32'($urandom_range(0, 3)) << (IW + 2)) | (32'($urandom_range(0, 7)) << 2);
    endfunction

    initial begin
        logic [31:0] pce, pcf, ptg;
        logic pte;
        br_type_e ty;

        rst = 1'b1;
        drive(32'h0, NOBRANCH, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0);
        @(posedge clk); #1;
        m_reset();
        rst = 1'b0;

        drive(32'h100, NOBRANCH, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0); #1;
        chk("reset_pred_taken", {31'h0, bpi.PredTakenF}, 32'h0);
        chk("reset_pred_target", bpi.PredTargetF, 32'h0);
        step();

        drive(32'h100, BEQ, 32'h100, 1, 32'h140, 0, 32'h0, 0, 0); #1;
        chk("alloc_mispredict", {31'h0, bpi.MispredictE}, 32'h1);
        chk("alloc_recover", bpi.RecoverPCE, 32'h140);
        chk("same_cycle_old", {31'h0, bpi.PredTakenF}, 32'h0);
        step();
        drive(32'h100, NOBRANCH, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0); #1;
        chk("alloc_pred_taken", {31'h0, bpi.PredTakenF}, 32'h1);
        chk("alloc_pred_target", bpi.PredTargetF, 32'h140);
        step();

        // 10 -> 01 -> 00
        drive(32'h100, BEQ, 32'h100, 0, 32'h140, 1, 32'h140, 0, 0); step();
        drive(32'h100, BEQ, 32'h100, 0, 32'h140, 0, 32'h0, 0, 0); #1;
        chk("nt_no_mispredict", {31'h0, bpi.MispredictE}, 32'h0);
        step();
        drive(32'h100, NOBRANCH, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0); #1;
        chk("nt_pred", {31'h0, bpi.PredTakenF}, 32'h0);
        step();

        // 00 -> 11 after four taken, then one not-taken leaves it predicting taken
        repeat (4) begin
            drive(32'h100, BEQ, 32'h100, 1, 32'h140, 0, 32'h0, 0, 0); step();
        end
        drive(32'h100, BEQ, 32'h100, 0, 32'h140, 1, 32'h140, 0, 0); step();
        drive(32'h100, NOBRANCH, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0); #1;
        chk("saturate_no_wrap", {31'h0, bpi.PredTakenF}, 32'h1);
        step();

        drive(32'h100, BNE, 32'h100 + (32'd4 << IW), 1, 32'h200, 0, 32'h0, 0, 0); step();
        drive(32'h100, NOBRANCH, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0); #1;
        chk("alias_miss", {31'h0, bpi.PredTakenF}, 32'h0);
        step();
        drive(32'h100 + (32'd4 << IW), NOBRANCH, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0); #1;
        chk("alias_new_target", bpi.PredTargetF, 32'h200);
        step();

        drive(32'hFFFF_FFFC, BLT, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h40, 1, 0); #1;
        chk("stall_no_mispredict", {31'h0, bpi.MispredictE}, 32'h0);
        step();
        bpi.BranchTypeE = NOBRANCH; #1;
        chk("stall_table_unchanged", {31'h0, bpi.PredTakenF}, 32'h0);
        bpi.BranchTypeE = BLT; bpi.StallE = 1'b0; #1;
        chk("wrap_mispredict", {31'h0, bpi.MispredictE}, 32'h1);
        chk("wrap_recover", bpi.RecoverPCE, 32'h0);
        step();

        drive(32'h300, BGE, 32'h300, 1, 32'h380, 0, 32'h0, 0, 1); step();
        drive(32'h300, NOBRANCH, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0); #1;
        chk("flush_no_update", {31'h0, bpi.PredTakenF}, 32'h0);
        step();

        for (int n = 0; n < 600; n++) begin
            pce = rpc();
            pcf = ($urandom_range(0, 3) == 0) ? pce : rpc();
            ty  = ($urandom_range(0, 4) == 0) ? NOBRANCH : br_type_e'($urandom_range(1, 6));
            if ($urandom_range(0, 1) == 1) begin
                pte = m_taken(pce);
                ptg = pte ? m_tgt[m_idx(pce)] : 32'h0;
            end else begin
                pte = 1'($urandom_range(0, 1));
                ptg = 32'($urandom_range(0, 15)) << 4;
            end
            rst = ($urandom_range(0, 99) == 0);
            drive(pcf, ty, pce, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 4,
                  pte, ptg, $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
            step();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
